// File: rtl/signal_shrinker.sv
// Trailing-edge-aligned pulse shrinker: trims the first L-1 cycles of each SIG_IN pulse,
// drops pulses shorter than L, applies a re-trigger holdoff and reports qualified pulse widths.
module signal_shrinker #(
  parameter int MAX_SHRINK_LEN_WIDTH = 5,
  parameter int WIDTH_CNT_WIDTH      = 16
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [MAX_SHRINK_LEN_WIDTH-1:0] SHRINK_LEN,
  input  logic [MAX_SHRINK_LEN_WIDTH-1:0] HOLDOFF_LEN,
  input  logic                            SIG_IN,
  output logic                            SIG_OUT,
  output logic                            RISE_PULSE,
  output logic                            WIDTH_VALID,
  output logic [WIDTH_CNT_WIDTH-1:0]      WIDTH_OUT
);

  localparam int MSLW = MAX_SHRINK_LEN_WIDTH;
  localparam int WCW  = WIDTH_CNT_WIDTH;
  localparam int CW   = (WCW > MSLW + 1) ? WCW : MSLW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMING  = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  localparam logic [MSLW:0]   E_ONE    = 1;
  localparam logic [MSLW-1:0] R_ONE    = 1;
  localparam logic [WCW-1:0]  WCNT_ONE = 1;
  localparam logic [CW-1:0]   WCNT_CAP = CW'({WCW{1'b1}});

  logic [1:0]      state;
  logic [MSLW-1:0] len_q;
  logic [MSLW-1:0] hold_q;
  logic [MSLW-1:0] run;
  logic [MSLW-1:0] ho;
  logic [WCW-1:0]  wcnt;

  logic [MSLW:0]   eff_len;
  logic [MSLW:0]   hold_ext;
  logic [MSLW:0]   run_nxt;
  logic [MSLW:0]   ho_nxt;
  logic [CW-1:0]   len_ext;
  logic [WCW-1:0]  wcnt_init;
  logic [WCW-1:0]  wcnt_sat;

  // A zero length behaves as one; the initial width count saturates if L exceeds the counter range
  always_comb begin
    eff_len   = (len_q == '0) ? E_ONE : {1'b0, len_q};
    hold_ext  = {1'b0, hold_q};
    run_nxt   = {1'b0, run} + E_ONE;
    ho_nxt    = {1'b0, ho} + E_ONE;
    len_ext   = CW'(eff_len);
    wcnt_init = (len_ext > WCNT_CAP) ? '1 : len_ext[WCW-1:0];
    wcnt_sat  = (wcnt == '1) ? wcnt : wcnt + WCNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      len_q       <= SHRINK_LEN;
      hold_q      <= HOLDOFF_LEN;
      run         <= '0;
      ho          <= '0;
      wcnt        <= '0;
      SIG_OUT     <= 1'b0;
      RISE_PULSE  <= 1'b0;
      WIDTH_VALID <= 1'b0;
      WIDTH_OUT   <= '0;
    end else begin
      RISE_PULSE  <= 1'b0;
      WIDTH_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (SIG_IN) begin
            if (eff_len == E_ONE) begin
              state      <= ST_ACTIVE;
              SIG_OUT    <= 1'b1;
              RISE_PULSE <= 1'b1;
              wcnt       <= WCNT_ONE;
            end else begin
              state <= ST_ARMING;
              run   <= R_ONE;
            end
          end
        end
        ST_ARMING: begin
          if (!SIG_IN) begin
            state <= ST_IDLE;
            run   <= '0;
          end else if (run_nxt == eff_len) begin
            state      <= ST_ACTIVE;
            SIG_OUT    <= 1'b1;
            RISE_PULSE <= 1'b1;
            wcnt       <= wcnt_init;
            run        <= '0;
          end else begin
            run <= run_nxt[MSLW-1:0];
          end
        end
        ST_ACTIVE: begin
          if (SIG_IN) begin
            wcnt <= wcnt_sat;
          end else begin
            SIG_OUT     <= 1'b0;
            WIDTH_OUT   <= wcnt;
            WIDTH_VALID <= 1'b1;
            ho          <= '0;
            state       <= (hold_q != '0) ? ST_HOLDOFF : ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (ho_nxt == hold_ext) begin
            state <= ST_IDLE;
            ho    <= '0;
          end else begin
            ho <= ho_nxt[MSLW-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_shrinker.sv
// Directed bench for signal_shrinker; a second instance with a 4-bit width counter covers saturation.
module tb_signal_shrinker;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] SHRINK_LEN;
  logic [4:0] HOLDOFF_LEN;
  logic       SIG_IN;
  logic       SIG_OUT, RISE_PULSE, WIDTH_VALID;
  logic [15:0] WIDTH_OUT;
  logic       sig_out4, rise_pulse4, width_valid4;
  logic [3:0] width_out4;

  int total = 0;
  int bad   = 0;

  signal_shrinker #(.MAX_SHRINK_LEN_WIDTH(5), .WIDTH_CNT_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .SHRINK_LEN(SHRINK_LEN), .HOLDOFF_LEN(HOLDOFF_LEN),
    .SIG_IN(SIG_IN), .SIG_OUT(SIG_OUT), .RISE_PULSE(RISE_PULSE),
    .WIDTH_VALID(WIDTH_VALID), .WIDTH_OUT(WIDTH_OUT)
  );

  signal_shrinker #(.MAX_SHRINK_LEN_WIDTH(5), .WIDTH_CNT_WIDTH(4)) dut_sat (
    .CLK(CLK), .RESET(RESET), .SHRINK_LEN(SHRINK_LEN), .HOLDOFF_LEN(HOLDOFF_LEN),
    .SIG_IN(SIG_IN), .SIG_OUT(sig_out4), .RISE_PULSE(rise_pulse4),
    .WIDTH_VALID(width_valid4), .WIDTH_OUT(width_out4)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic doReset(input logic [4:0] len, input logic [4:0] hold);
    RESET       = 1'b1;
    SHRINK_LEN  = len;
    HOLDOFF_LEN = hold;
    SIG_IN      = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  // Drive one sample, clock it in and compare the three level/strobe outputs
  task automatic applyStimulus(input logic sig, input logic exp_out, input logic exp_rise,
                               input logic exp_wv, input string tag);
    SIG_IN = sig;
    @(posedge CLK); #1;
    checkOutput({tag, "_out"},  32'(SIG_OUT),     32'(exp_out));
    checkOutput({tag, "_rise"}, 32'(RISE_PULSE),  32'(exp_rise));
    checkOutput({tag, "_wv"},   32'(WIDTH_VALID), 32'(exp_wv));
  endtask

  task automatic randomFollow(input logic [4:0] len, input string tag);
    logic s;
    logic prev;
    int   ones;
    doReset(len, 5'd0);
    prev = 1'b0;
    ones = 0;
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom_range(0, 1));
      if (k == 39) s = 1'b0;
      applyStimulus(s, s, s && !prev, !s && prev, tag);
      if (!s && prev) checkOutput({tag, "_w"}, 32'(WIDTH_OUT), ones);
      ones = s ? ones + 1 : 0;
      prev = s;
    end
  endtask

  initial begin
    int high4;
    RESET = 1'b1; SHRINK_LEN = 5'd4; HOLDOFF_LEN = 5'd0; SIG_IN = 1'b0;
    @(posedge CLK); #1;
    checkOutput("rst_out",  32'(SIG_OUT),     0);
    checkOutput("rst_rise", 32'(RISE_PULSE),  0);
    checkOutput("rst_wv",   32'(WIDTH_VALID), 0);
    checkOutput("rst_w",    32'(WIDTH_OUT),   0);
    RESET = 1'b0;

    // L=4 H=0, 10-cycle pulse: rise at edge 3, fall at edge 10
    for (int k = 0; k < 14; k++)
      applyStimulus(k < 10, k >= 3 && k < 10, k == 3, k == 10, "t1");
    checkOutput("t1_w", 32'(WIDTH_OUT), 10);

    // 3-cycle pulse suppressed, then a 4-cycle pulse yields one output cycle
    for (int k = 0; k < 14; k++)
      applyStimulus((k < 3) || (k >= 6 && k < 10), k == 9, k == 9, k == 10, "t2");
    checkOutput("t2_w", 32'(WIDTH_OUT), 4);

    randomFollow(5'd1, "t3a");
    randomFollow(5'd0, "t3b");

    // L=4 H=5: second pulse is only seen after the holdoff expires
    doReset(5'd4, 5'd5);
    for (int k = 0; k < 26; k++) begin
      applyStimulus((k < 10) || (k >= 12 && k < 20), (k >= 3 && k < 10) || k == 19,
                    k == 3 || k == 19, k == 10 || k == 20, "t4");
      if (k == 10) checkOutput("t4_w1", 32'(WIDTH_OUT), 10);
    end
    checkOutput("t4_w2", 32'(WIDTH_OUT), 4);

    // L=2, 20-cycle pulse: 4-bit counter saturates at 15
    doReset(5'd2, 5'd0);
    high4 = 0;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(k < 20, k >= 1 && k < 20, k == 1, k == 20, "t5");
      high4 += int'(sig_out4);
    end
    checkOutput("t5_w16", 32'(WIDTH_OUT), 20);
    checkOutput("t5_w4",  32'(width_out4), 15);
    checkOutput("t5_hi4", high4, 19);

    // Reset while ACTIVE with a new length of 3
    doReset(5'd4, 5'd0);
    for (int k = 0; k < 6; k++)
      applyStimulus(1'b1, k >= 3, k == 3, 1'b0, "t6a");
    RESET = 1'b1; SHRINK_LEN = 5'd3; SIG_IN = 1'b1;
    @(posedge CLK); #1;
    checkOutput("t6_rst_out", 32'(SIG_OUT),     0);
    checkOutput("t6_rst_rise", 32'(RISE_PULSE), 0);
    checkOutput("t6_rst_wv",  32'(WIDTH_VALID), 0);
    checkOutput("t6_rst_w",   32'(WIDTH_OUT),   0);
    RESET = 1'b0;
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t6b");
    for (int k = 0; k < 8; k++)
      applyStimulus(k < 5, k >= 2 && k < 5, k == 2, k == 5, "t6c");
    checkOutput("t6_w", 32'(WIDTH_OUT), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
